// File: rtl/cordic_axi_lite_slave_if.sv
// AXI4-Lite bus bundle between a host master and the CORDIC register slave.
interface cordic_axi_lite_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/cordic_axi_lite_slave.sv
// AXI4-Lite slave exposing four 32-bit control registers to the CORDIC core,
// with independent one-entry AW/W buffers and a one-cycle-latency read path.
module cordic_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  cordic_axi_lite_slave_if.slave        s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
  output logic [3:0]                    wr_pulse_o
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                input logic [DW-1:0] new_val,
                                                input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_val;
    for (int i = 0; i < SW; i++)
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

  logic          aw_full, w_full;
  logic [1:0]    aw_idx;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic          awready, wready, arready;
  logic          bvalid, rvalid;
  logic [DW-1:0] rdata;
  logic [DW-1:0] regs [4];
  logic [3:0]    wr_pulse;

  logic aw_hs, w_hs, ar_hs, commit;
  logic aw_full_n, w_full_n, bvalid_n, rvalid_n;

  // Next-state of the handshake flags; every READY is registered from these,
  // so no output ever follows a bus input combinationally.
  always_comb begin
    aw_hs     = s_axi.S_AXI_AWVALID & awready;
    w_hs      = s_axi.S_AXI_WVALID  & wready;
    ar_hs     = s_axi.S_AXI_ARVALID & arready;
    commit    = aw_full & w_full;
    aw_full_n = ~commit & (aw_full | aw_hs);
    w_full_n  = ~commit & (w_full  | w_hs);
    bvalid_n  = commit | (bvalid & ~s_axi.S_AXI_BREADY);
    rvalid_n  = ar_hs  | (rvalid & ~s_axi.S_AXI_RREADY);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      arready  <= 1'b0;
      bvalid   <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      wr_pulse <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      aw_full  <= aw_full_n;
      w_full   <= w_full_n;
      bvalid   <= bvalid_n;
      rvalid   <= rvalid_n;
      awready  <= ~aw_full_n & ~bvalid_n;
      wready   <= ~w_full_n  & ~bvalid_n;
      arready  <= ~rvalid_n;
      wr_pulse <= commit ? (4'b0001 << aw_idx) : 4'b0000;
      if (aw_hs) aw_idx <= s_axi.S_AXI_AWADDR[3:2];
      if (w_hs) begin
        w_data <= s_axi.S_AXI_WDATA;
        w_strb <= s_axi.S_AXI_WSTRB;
      end
      if (commit) regs[aw_idx] <= merge_bytes(regs[aw_idx], w_data, w_strb);
      // Read samples the pre-commit value when both land on one edge.
      if (ar_hs) rdata <= regs[s_axi.S_AXI_ARADDR[3:2]];
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign reg0_o     = regs[0];
  assign reg1_o     = regs[1];
  assign reg2_o     = regs[2];
  assign reg3_o     = regs[3];
  assign wr_pulse_o = wr_pulse;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_cordic_axi_lite_slave.sv
// Scoreboard bench for the CORDIC AXI4-Lite register slave.
module tb_cordic_axi_lite_slave;
  logic        tb_ACLK;
  logic        tb_ARESETN;
  logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
  logic [3:0]  wr_pulse_o;

  cordic_axi_lite_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) s_if ();

  cordic_axi_lite_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK    (tb_ACLK),
    .S_AXI_ARESETN (tb_ARESETN),
    .s_axi         (s_if),
    .reg0_o        (reg0_o),
    .reg1_o        (reg1_o),
    .reg2_o        (reg2_o),
    .reg3_o        (reg3_o),
    .wr_pulse_o    (wr_pulse_o)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [31:0] model [4];
  logic [31:0] rq [$];
  logic [1:0]  bq [$];
  logic [3:0]  pulse_or;
  int          pulse_cnt;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic sample_pulse();
    if (wr_pulse_o !== 4'b0000) begin
      pulse_or |= wr_pulse_o;
      pulse_cnt++;
    end
  endtask

  function automatic logic [31:0] reg_out(input int idx);
    case (idx)
      0:       return reg0_o;
      1:       return reg1_o;
      2:       return reg2_o;
      default: return reg3_o;
    endcase
  endfunction

  function automatic logic [31:0] strobe_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_awready"}, 32'(s_if.S_AXI_AWREADY), 32'd0);
    check_val({tag, "_wready"},  32'(s_if.S_AXI_WREADY),  32'd0);
    check_val({tag, "_arready"}, 32'(s_if.S_AXI_ARREADY), 32'd0);
    check_val({tag, "_bvalid"},  32'(s_if.S_AXI_BVALID),  32'd0);
    check_val({tag, "_rvalid"},  32'(s_if.S_AXI_RVALID),  32'd0);
    check_val({tag, "_resp"},    32'({s_if.S_AXI_BRESP, s_if.S_AXI_RRESP}), 32'd0);
    check_val({tag, "_rdata"},   s_if.S_AXI_RDATA, 32'd0);
    check_val({tag, "_pulse"},   32'(wr_pulse_o), 32'd0);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("%s_reg%0d", tag, i), reg_out(i), 32'd0);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int bready_dly, input string tag);
    int         cyc;
    bit         aw_done, w_done, aw_fire, w_fire;
    int         extra_b;
    logic [1:0] bresp0;
    model[addr[3:2]] = strobe_merge(model[addr[3:2]], data, strb);
    bq.push_back(2'b00);
    pulse_or  = 4'b0000;
    pulse_cnt = 0;
    aw_done   = 1'b0;
    w_done    = 1'b0;
    cyc       = 0;
    s_if.S_AXI_AWADDR = addr;
    s_if.S_AXI_WDATA  = data;
    s_if.S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      s_if.S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
      s_if.S_AXI_WVALID  = !w_done && cyc >= w_dly;
      aw_fire = s_if.S_AXI_AWVALID && s_if.S_AXI_AWREADY;
      w_fire  = s_if.S_AXI_WVALID && s_if.S_AXI_WREADY;
      tick();
      sample_pulse();
      aw_done |= aw_fire;
      w_done  |= w_fire;
      cyc++;
    end
    s_if.S_AXI_AWVALID = 1'b0;
    s_if.S_AXI_WVALID  = 1'b0;
    check_val({tag, "_accept"}, 32'({aw_done, w_done}), 32'd3);
    cyc = 0;
    while (!s_if.S_AXI_BVALID && cyc < 10) begin
      tick();
      sample_pulse();
      cyc++;
    end
    check_val({tag, "_bvalid"}, 32'(s_if.S_AXI_BVALID), 32'd1);
    bresp0 = s_if.S_AXI_BRESP;
    for (int k = 0; k < bready_dly; k++) begin
      check_val({tag, "_bhold"}, 32'({s_if.S_AXI_BVALID, s_if.S_AXI_BRESP}), 32'({1'b1, bresp0}));
      check_val({tag, "_rdy_low"}, 32'({s_if.S_AXI_AWREADY, s_if.S_AXI_WREADY}), 32'd0);
      tick();
      sample_pulse();
    end
    s_if.S_AXI_BREADY = 1'b1;
    check_val({tag, "_bresp"}, 32'(s_if.S_AXI_BRESP), 32'(bq.pop_front()));
    tick();
    sample_pulse();
    s_if.S_AXI_BREADY = 1'b0;
    extra_b = 0;
    for (int k = 0; k < 3; k++) begin
      if (s_if.S_AXI_BVALID) extra_b++;
      tick();
      sample_pulse();
    end
    check_val({tag, "_extra_b"}, 32'(extra_b), 32'd0);
    check_val({tag, "_pulse"}, 32'(pulse_or), 32'(4'b0001 << addr[3:2]));
    check_val({tag, "_pulse_cnt"}, 32'(pulse_cnt), 32'd1);
    check_val({tag, "_reg_o"}, reg_out(int'(addr[3:2])), model[addr[3:2]]);
  endtask

  task automatic axi_read(input logic [3:0] addr, input int rready_dly, input string tag);
    int          cyc;
    logic [31:0] first;
    rq.push_back(model[addr[3:2]]);
    s_if.S_AXI_ARADDR  = addr;
    s_if.S_AXI_ARVALID = 1'b1;
    cyc = 0;
    while (!s_if.S_AXI_ARREADY && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    s_if.S_AXI_ARVALID = 1'b0;
    check_val({tag, "_rvalid"}, 32'(s_if.S_AXI_RVALID), 32'd1);
    first = s_if.S_AXI_RDATA;
    for (int k = 0; k < rready_dly; k++) begin
      tick();
      check_val({tag, "_rhold"}, 32'(s_if.S_AXI_RVALID), 32'd1);
      check_val({tag, "_rdata_hold"}, s_if.S_AXI_RDATA, first);
    end
    s_if.S_AXI_RREADY = 1'b1;
    check_val({tag, "_rdata"}, s_if.S_AXI_RDATA, rq.pop_front());
    check_val({tag, "_rresp"}, 32'(s_if.S_AXI_RRESP), 32'd0);
    tick();
    s_if.S_AXI_RREADY = 1'b0;
    check_val({tag, "_rvalid_clr"}, 32'(s_if.S_AXI_RVALID), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seq_d [4];
    seq_d = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
    tb_ARESETN         = 1'b0;
    s_if.S_AXI_AWADDR  = '0;
    s_if.S_AXI_AWPROT  = '0;
    s_if.S_AXI_AWVALID = 1'b0;
    s_if.S_AXI_WDATA   = '0;
    s_if.S_AXI_WSTRB   = '0;
    s_if.S_AXI_WVALID  = 1'b0;
    s_if.S_AXI_BREADY  = 1'b0;
    s_if.S_AXI_ARADDR  = '0;
    s_if.S_AXI_ARPROT  = '0;
    s_if.S_AXI_ARVALID = 1'b0;
    s_if.S_AXI_RREADY  = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'd0;

    #2;
    check_reset_outputs("por");
    #20;
    tb_ARESETN = 1'b1;
    #1;
    check_val("rdy_before_edge", 32'({s_if.S_AXI_AWREADY, s_if.S_AXI_WREADY, s_if.S_AXI_ARREADY}), 32'd0);
    tick();
    check_val("rdy_after_edge", 32'({s_if.S_AXI_AWREADY, s_if.S_AXI_WREADY, s_if.S_AXI_ARREADY}), 32'd7);

    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), seq_d[i], 4'hF, 0, 0, 0, $sformatf("seq%0d_wr", i));
      axi_read(4'(i * 4), 0, $sformatf("seq%0d_rd", i));
    end

    axi_write(4'h4, 32'h11223344, 4'b0101, 0, 0, 0, "strb_wr");
    check_val("strb_reg1", reg1_o, 32'hAB220044);
    axi_read(4'h4, 0, "strb_rd");
    axi_write(4'h4, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, "nostrb_wr");
    axi_read(4'h4, 0, "nostrb_rd");

    axi_write(4'hC, 32'h12345678, 4'hF, 3, 0, 0, "wfirst_wr");
    axi_read(4'hC, 0, "wfirst_rd");
    axi_write(4'hC, 32'h9ABCDEF0, 4'hF, 0, 2, 0, "awfirst_wr");
    axi_read(4'hD, 0, "awfirst_rd");
    axi_write(4'hC, 32'hBEEF0011, 4'hF, 0, 0, 0, "same_wr");
    axi_read(4'hC, 0, "same_rd");

    axi_write(4'h0, 32'hCAFEF00D, 4'hF, 0, 0, 5, "bp_wr");
    axi_read(4'h0, 5, "bp_rd");

    // Same-edge read and write commit on 0x8.
    s_if.S_AXI_AWADDR  = 4'h8;
    s_if.S_AXI_WDATA   = 32'h00000000;
    s_if.S_AXI_WSTRB   = 4'hF;
    s_if.S_AXI_AWVALID = 1'b1;
    s_if.S_AXI_WVALID  = 1'b1;
    check_val("se_wrdy", 32'({s_if.S_AXI_AWREADY, s_if.S_AXI_WREADY}), 32'd3);
    tick();
    s_if.S_AXI_AWVALID = 1'b0;
    s_if.S_AXI_WVALID  = 1'b0;
    s_if.S_AXI_ARADDR  = 4'h8;
    s_if.S_AXI_ARVALID = 1'b1;
    rq.push_back(model[2]);
    bq.push_back(2'b00);
    check_val("se_arrdy", 32'(s_if.S_AXI_ARREADY), 32'd1);
    tick();
    s_if.S_AXI_ARVALID = 1'b0;
    model[2] = 32'h00000000;
    check_val("se_rvalid", 32'(s_if.S_AXI_RVALID), 32'd1);
    check_val("se_rdata_old", s_if.S_AXI_RDATA, rq.pop_front());
    check_val("se_pulse", 32'(wr_pulse_o), 32'h4);
    check_val("se_bvalid", 32'(s_if.S_AXI_BVALID), 32'd1);
    check_val("se_bresp", 32'(s_if.S_AXI_BRESP), 32'(bq.pop_front()));
    s_if.S_AXI_BREADY = 1'b1;
    s_if.S_AXI_RREADY = 1'b1;
    tick();
    s_if.S_AXI_BREADY = 1'b0;
    s_if.S_AXI_RREADY = 1'b0;
    check_val("se_reg2", reg2_o, 32'h00000000);
    axi_read(4'h8, 0, "se_after");

    // Reset while an accepted AW waits for its W.
    axi_read(4'h0, 0, "pre_rst");
    s_if.S_AXI_AWADDR  = 4'h4;
    s_if.S_AXI_AWVALID = 1'b1;
    check_val("mid_awrdy", 32'(s_if.S_AXI_AWREADY), 32'd1);
    tick();
    s_if.S_AXI_AWVALID = 1'b0;
    #2;
    tb_ARESETN = 1'b0;
    #1;
    check_reset_outputs("async");
    tick();
    tick();
    #3;
    tb_ARESETN = 1'b1;
    #1;
    check_val("rel_rdy_low", 32'({s_if.S_AXI_AWREADY, s_if.S_AXI_WREADY, s_if.S_AXI_ARREADY}), 32'd0);
    pulse_or  = 4'b0000;
    pulse_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      sample_pulse();
    end
    check_val("rel_no_pulse", 32'(pulse_cnt), 32'd0);
    for (int i = 0; i < 4; i++) model[i] = 32'd0;
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0, $sformatf("rel%0d_rd", i));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/cordic_axi_lite_slave.md
CORDIC_AXI_LITE_SLAVE -- requirements
Module: cordic_axi_lite_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; bits [3:2] select one of 4 registers.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- S_AXI_ACLK  in  1  sole clock; all state changes on its rising edge.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- reg0_o..reg3_o  out  32 each  current register contents, for the CORDIC core.
- wr_pulse_o  out  4  one-cycle strobe per register on write commit.

Function
REQ-004 SHALL hold four 32-bit registers REG0..REG3 at byte offsets 0x0, 0x4, 0x8 and 0xC; AWADDR/ARADDR bits [1:0] are ignored.
REQ-005 SHALL accept AW and W independently, each into a one-entry holding buffer:
- AWREADY=1 while the AW buffer is empty and BVALID=0.
- WREADY=1 while the W buffer is empty and BVALID=0.
- AW and W SHALL be accepted in either order or in the same cycle.
REQ-006 SHALL commit a write on the edge after both buffers are full:
- update each byte i of the addressed register where WSTRB[i]=1; bytes with WSTRB[i]=0 keep their value.
- pulse wr_pulse_o[addr] high for exactly that one cycle, even when WSTRB=0.
- set BVALID=1 with BRESP=2'b00 and clear both buffers.
REQ-007 SHALL hold BVALID=1 and BRESP stable until the cycle BREADY=1, then clear BVALID on that edge; no new AW/W SHALL be accepted while BVALID=1.
REQ-008 SHALL assert ARREADY=1 while RVALID=0; on an AR handshake, RDATA SHALL be loaded with the addressed register and RVALID set on the same edge (one-cycle latency), with RRESP=2'b00.
REQ-009 SHALL hold RVALID, RDATA and RRESP stable until the RREADY handshake; RVALID clears on that edge.
REQ-010 Read and write paths SHALL operate concurrently; a read of a register whose write commits on the same edge SHALL return the pre-write value.
REQ-011 BVALID SHALL NOT depend combinationally on BREADY, nor RVALID on RREADY; all outputs SHALL be registered.
REQ-012 reg0_o..reg3_o SHALL reflect register contents continuously, i.e. updated value visible the cycle after commit.

Reset
REQ-013 While S_AXI_ARESETN=0, asynchronously: REG0..REG3=0, both buffers empty, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, wr_pulse_o=0.
REQ-014 READY outputs SHALL rise no earlier than the first rising edge after reset deassertion; a transaction in flight at reset assertion SHALL be discarded with no register update.

Verification
REQ-015 Sequential write/read: write 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x0, 0x4, 0x8 and 0xC, reading back after each -> each read returns the written value; all BRESP/RRESP=OKAY; wr_pulse_o pulses 0001, 0010, 0100, 1000.
REQ-016 Byte strobes: REG1=0xABCD0001, then write 0x11223344 with WSTRB=4'b0101 -> readback 0xAB220044.
REQ-017 Channel ordering: W presented 3 cycles before AW, then AW before W, then both in the same cycle -> every case commits exactly once, with correct data and a single BVALID.
REQ-018 Backpressure: BREADY and RREADY held low for 5 cycles -> BVALID/RVALID and RDATA stay stable; AWREADY/WREADY stay low until B completes.
REQ-019 Same-edge read/write on 0x8 (old 0xDEAD0011, new 0x0) -> RDATA=0xDEAD0011; a following read returns 0x00000000.
REQ-020 Reset mid-write (AW accepted, W pending) asserted asynchronously between clock edges -> all outputs at reset values immediately; after release, all registers read 0 and no wr_pulse_o was emitted.
